// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_pkg
// Purpose  : Shared types and constants for the fetch-stage control sequencer.
//            Holds the sequencer state encoding, the canonical NOP encoding
//            injected by a fetch flush, and the default trap vector.
// Revision : 1.0  initial release
// ============================================================================
package fetch_ctrl_pkg;

   // Sequencer states: normal fetch, NOP drain towards halt, and stopped.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fc_state_e;

   // addi x0, x0, 0 -- what the fetch stage emits while flushed.
   localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;

   // Word-aligned PC loaded when a redirect target is misaligned.
   localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

   // A redirect target traps unless it falls on a 32-bit word boundary.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/event_counter.sv
`default_nettype none
// ============================================================================
// Module   : event_counter
// Purpose  : Free-running event counter; increments by one on every cycle
//            that inc is high and wraps modulo 2^CNT_W (no saturation).
// Ports    : clk   - clock, rising edge
//            reset - synchronous, active-high; clears the count
//            inc   - count this cycle
//            count - current count value (registered)
// Revision : 1.0  initial release
// ============================================================================
module event_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc) begin
         count_d = count_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : event_counter
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Fetch-stage pipeline control sequencer. Arbitrates EX redirects,
//            misaligned-target traps, ID load-use hazards and halt/resume,
//            and owns every PC-steering decision for the fetch stage.
//            Priority within a cycle: redirect/trap > load-use > halt.
// Ports    : clk, reset                 - clock / synchronous active-high reset
//            ex_redirect_valid/_target  - taken branch/jump resolved in EX
//            id_load_use                - ID depends on the load now in EX
//            halt_req, resume_req       - halt level request / resume pulse
//            if_stall, if_flush,
//            if_pc_sel, if_pc_in        - fetch stage controls
//            id_stall, id_flush         - IF/ID register hold / kill
//            ex_bubble                  - NOP insertion into ID/EX
//            trap_valid, trap_epc       - trap pulse and faulting target
//            halted                     - pipeline drained and stopped
//            stall_count, flush_count   - wrapping performance counters
// Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT,
   parameter int          DRAIN_CYCLES = 3,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_redirect_valid,
   input  logic [31:0]      ex_redirect_target,
   input  logic             id_load_use,
   input  logic             halt_req,
   input  logic             resume_req,
   output logic             if_stall,
   output logic             if_flush,
   output logic             if_pc_sel,
   output logic [31:0]      if_pc_in,
   output logic             id_stall,
   output logic             id_flush,
   output logic             ex_bubble,
   output logic             trap_valid,
   output logic [31:0]      trap_epc,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

   fc_state_e   state_q, state_d;
   logic [3:0]  drain_q, drain_d;
   logic [31:0] epc_q,   epc_d;

   logic        take_redirect;
   logic        misaligned;
   logic        stall_inc;
   logic        flush_inc;

   // The pipeline is empty while HALTED, so redirects there are dropped.
   assign take_redirect = ex_redirect_valid && (state_q != HALTED);
   assign misaligned    = is_misaligned(ex_redirect_target);

   // ------------------------------------------------------------------
   // Output decode and next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      if_stall   = 1'b0;
      if_flush   = 1'b0;
      if_pc_sel  = 1'b0;
      if_pc_in   = 32'h0;
      id_stall   = 1'b0;
      id_flush   = 1'b0;
      ex_bubble  = 1'b0;
      trap_valid = 1'b0;
      halted     = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
      state_d    = state_q;
      drain_d    = drain_q;
      epc_d      = epc_q;

      // All controls stay idle while reset is held.
      if (!reset) begin
         // Outputs, highest priority first.
         if (state_q == HALTED) begin
            halted   = 1'b1;
            if_stall = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
         end else if (take_redirect) begin
            // Redirect wins over the DRAIN stall so the new PC is fetched.
            if_pc_sel  = 1'b1;
            if_pc_in   = misaligned ? TRAP_VECTOR : ex_redirect_target;
            if_flush   = 1'b1;
            id_flush   = 1'b1;
            trap_valid = misaligned;
            flush_inc  = 1'b1;
            if (misaligned) begin
               epc_d = ex_redirect_target;
            end
         end else if (state_q == DRAIN) begin
            if_stall = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
         end else if (id_load_use) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
            stall_inc = 1'b1;
         end

         // State transitions.
         unique case (state_q)
            RUN: begin
               // A load-use stall defers the halt by a cycle.
               if (!take_redirect && !id_load_use && halt_req) begin
                  state_d = DRAIN;
                  drain_d = DRAIN_LOAD;
               end
            end
            DRAIN: begin
               if (!halt_req) begin
                  state_d = RUN;
               end else if (take_redirect) begin
                  // Fresh wrong-path work entered the pipe: restart the drain.
                  drain_d = DRAIN_LOAD;
               end else if (drain_q == 4'd1) begin
                  state_d = HALTED;
                  drain_d = 4'd0;
               end else begin
                  drain_d = drain_q - 4'd1;
               end
            end
            HALTED: begin
               if (resume_req) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         drain_q <= 4'd0;
         epc_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         epc_q   <= epc_d;
      end
   end

   assign trap_epc = epc_q;

   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
   event_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .count (stall_count)
   );

   event_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc),
      .count (flush_count)
   );

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl: a directed cycle table,
//            hand-written halt/resume and counter-wrap sequences, and a
//            randomized run compared against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

   localparam logic [31:0] TV    = 32'h0000_0100;
   localparam int          DRAIN = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        rv;
   logic [31:0] tgt;
   logic        lu, hr, rs;
   logic        if_stall, if_flush, if_pc_sel, id_stall, id_flush;
   logic        ex_bubble, trap_valid, halted;
   logic [31:0] if_pc_in, trap_epc;
   logic [15:0] stall_count, flush_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(
      .TRAP_VECTOR  (TV),
      .DRAIN_CYCLES (DRAIN),
      .CNT_W        (16)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .ex_redirect_valid  (rv),
      .ex_redirect_target (tgt),
      .id_load_use        (lu),
      .halt_req           (hr),
      .resume_req         (rs),
      .if_stall           (if_stall),
      .if_flush           (if_flush),
      .if_pc_sel          (if_pc_sel),
      .if_pc_in           (if_pc_in),
      .id_stall           (id_stall),
      .id_flush           (id_flush),
      .ex_bubble          (ex_bubble),
      .trap_valid         (trap_valid),
      .trap_epc           (trap_epc),
      .halted             (halted),
      .stall_count        (stall_count),
      .flush_count        (flush_count)
   );

   // Flag vector order: if_stall if_flush if_pc_sel id_stall id_flush
   //                    ex_bubble trap_valid halted
   localparam logic [7:0] F_IDLE = 8'b0000_0000;
   localparam logic [7:0] F_RDR  = 8'b0110_1000;
   localparam logic [7:0] F_TRAP = 8'b0110_1010;
   localparam logic [7:0] F_LU   = 8'b1001_0100;
   localparam logic [7:0] F_DRN  = 8'b1100_1000;
   localparam logic [7:0] F_HLT  = 8'b1100_1001;

   typedef struct {
      logic        rst, rv;
      logic [31:0] tgt;
      logic        lu, hr, rs;
      logic [7:0]  flags;
      logic [31:0] pc, epc;
      logic [15:0] sc, fc;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic v, input logic [31:0] t,
                               input logic l, input logic h, input logic s,
                               input logic [7:0] f, input logic [31:0] p,
                               input logic [31:0] e, input logic [15:0] sc,
                               input logic [15:0] fc);
      vec_t x;
      x.rst = r; x.rv = v; x.tgt = t; x.lu = l; x.hr = h; x.rs = s;
      x.flags = f; x.pc = p; x.epc = e; x.sc = sc; x.fc = fc;
      return x;
   endfunction

   function automatic logic [7:0] dut_flags();
      return {if_stall, if_flush, if_pc_sel, id_stall, id_flush,
              ex_bubble, trap_valid, halted};
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [31:0] t,
                        input logic l, input logic h, input logic s);
      reset = r; rv = v; tgt = t; lu = l; hr = h; rs = s;
   endtask

   task automatic compare_all(input string tag, input int idx, input logic [7:0] f,
                              input logic [31:0] p, input logic [31:0] e,
                              input logic [15:0] sc, input logic [15:0] fc);
      chk({tag, "_flags"}, idx, {24'h0, dut_flags()}, {24'h0, f});
      chk({tag, "_pc_in"}, idx, if_pc_in, p);
      chk({tag, "_epc"},   idx, trap_epc, e);
      chk({tag, "_stall_count"}, idx, {16'h0, stall_count}, {16'h0, sc});
      chk({tag, "_flush_count"}, idx, {16'h0, flush_count}, {16'h0, fc});
   endtask

   // ------------------------------------------------------------------
   // Behavioural reference: mode 0=running, 1=draining, 2=halted.
   // ------------------------------------------------------------------
   int          m_mode;
   int          m_left;
   int unsigned m_sc, m_fc;
   logic [31:0] m_epc;

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_sc = 0; m_fc = 0; m_epc = 32'h0;
   endtask

   task automatic model_expect(output logic [7:0] f, output logic [31:0] p);
      logic redirect;
      f = F_IDLE; p = 32'h0;
      redirect = rv && (m_mode != 2);
      if (!reset) begin
         if (m_mode == 2)          f = F_HLT;
         else if (redirect) begin
            f = (tgt % 4 != 0) ? F_TRAP : F_RDR;
            p = (tgt % 4 != 0) ? TV : tgt;
         end
         else if (m_mode == 1)     f = F_DRN;
         else if (lu)              f = F_LU;
      end
   endtask

   task automatic model_advance();
      logic redirect;
      redirect = rv && (m_mode != 2);
      if (reset) begin
         model_reset();
         return;
      end
      if (redirect) begin
         m_fc = (m_fc + 1) % 65536;
         if (tgt % 4 != 0) m_epc = tgt;
      end
      if (m_mode == 0) begin
         if (!redirect && lu) m_sc = (m_sc + 1) % 65536;
         else if (!redirect && hr) begin m_mode = 1; m_left = DRAIN; end
      end else if (m_mode == 1) begin
         if (!hr)            m_mode = 0;
         else if (redirect)  m_left = DRAIN;
         else if (m_left == 1) m_mode = 2;
         else                m_left = m_left - 1;
      end else if (rs) begin
         m_mode = 0;
      end
   endtask

   vec_t tbl[$];

   initial begin
      logic [7:0]  ef;
      logic [31:0] ep, rnd;
      int          n;

      drive(1, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;

      // --------------------------- directed table ---------------------------
      //          rst rv tgt       lu hr rs flags   pc      epc     sc fc
      tbl.push_back(mk(1,1,32'h40, 0,0,0, F_IDLE, 32'h0,  32'h0,  0, 0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(0,0,32'h0, 0,0,0, F_IDLE, 32'h0, 32'h0, 0, 0));
      tbl.push_back(mk(0,1,32'h40, 0,0,0, F_RDR,  32'h40, 32'h0,  0, 0));
      tbl.push_back(mk(0,0,32'h0,  0,0,0, F_IDLE, 32'h0,  32'h0,  0, 1));
      tbl.push_back(mk(0,1,32'h42, 0,0,0, F_TRAP, TV,     32'h0,  0, 1));
      tbl.push_back(mk(0,0,32'h0,  0,0,0, F_IDLE, 32'h0,  32'h42, 0, 2));
      tbl.push_back(mk(0,0,32'h0,  1,0,0, F_LU,   32'h0,  32'h42, 0, 2));
      tbl.push_back(mk(0,1,32'h80, 1,0,0, F_RDR,  32'h80, 32'h42, 1, 2));
      tbl.push_back(mk(0,0,32'h0,  0,0,0, F_IDLE, 32'h0,  32'h42, 1, 3));
      tbl.push_back(mk(0,0,32'h0,  0,1,0, F_IDLE, 32'h0,  32'h42, 1, 3));
      tbl.push_back(mk(0,0,32'h0,  0,1,0, F_DRN,  32'h0,  32'h42, 1, 3));
      tbl.push_back(mk(0,1,32'h200,0,1,0, F_RDR,  32'h200,32'h42, 1, 3));
      tbl.push_back(mk(0,0,32'h0,  0,1,0, F_DRN,  32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,0,32'h0,  0,1,0, F_DRN,  32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,0,32'h0,  1,1,0, F_DRN,  32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,1,32'h300,0,1,0, F_HLT,  32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,0,32'h0,  0,0,0, F_HLT,  32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,0,32'h0,  0,0,1, F_HLT,  32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,0,32'h0,  0,0,0, F_IDLE, 32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,0,32'h0,  0,1,0, F_IDLE, 32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,0,32'h0,  0,0,0, F_DRN,  32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,0,32'h0,  0,0,0, F_IDLE, 32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,0,32'h0,  0,1,0, F_IDLE, 32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,0,32'h0,  0,1,0, F_DRN,  32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(1,0,32'h0,  0,1,0, F_IDLE, 32'h0,  32'h42, 1, 4));
      tbl.push_back(mk(0,0,32'h0,  0,0,0, F_IDLE, 32'h0,  32'h0,  0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].rv, tbl[i].tgt, tbl[i].lu, tbl[i].hr, tbl[i].rs);
         #3;
         compare_all("tbl", i, tbl[i].flags, tbl[i].pc, tbl[i].epc,
                     tbl[i].sc, tbl[i].fc);
         @(posedge clk);
         #1;
      end

      // ------------------- halt latency and resume sequence -------------------
      drive(0, 0, 0, 0, 1, 0);
      #3;
      n = 0;
      while (!halted && n < 20) begin
         @(posedge clk);
         #4;
         n++;
      end
      chk("halt_latency", 0, n, DRAIN + 1);
      hr = 1'b0; rs = 1'b1;
      @(posedge clk);
      #1;
      rs = 1'b0;
      #3;
      chk("resume_if_stall", 0, {31'h0, if_stall}, 32'h0);
      chk("resume_halted",   0, {31'h0, halted},   32'h0);
      @(posedge clk);
      #1;

      // ------------------------ randomized vs model --------------------------
      drive(1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         rv    = ($urandom_range(0, 4) == 0);
         rnd   = $urandom();
         tgt   = ($urandom_range(0, 3) == 0) ? rnd : {rnd[31:2], 2'b00};
         lu    = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) hr = ~hr;
         rs    = ($urandom_range(0, 7) == 0);
         #3;
         model_expect(ef, ep);
         compare_all("rnd", c, ef, ep, m_epc, m_sc[15:0], m_fc[15:0]);
         model_advance();
         @(posedge clk);
         #1;
      end

      // -------------------------- stall counter wrap --------------------------
      drive(1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 1, 0, 0);
      repeat (65535) @(posedge clk);
      #4;
      chk("wrap_pre",  0, {16'h0, stall_count}, 32'h0000_FFFF);
      @(posedge clk);
      #4;
      chk("wrap_post", 0, {16'h0, stall_count}, 32'h0);
      chk("wrap_flush_count", 0, {16'h0, flush_count}, 32'h0);
      lu = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Pipeline control sequencer for the instruction-fetch stage. Arbitrates branch/jump redirects from EX, load-use hazards from ID, misaligned-target traps and an external halt/resume request. Drives the fetch stage's `stall`, `flush`, `pc_sel` and `pc_in` inputs plus the ID/EX kill and hold signals. Sits beside the fetch stage in the core top level and owns all PC-steering decisions.

## Interface
- `TRAP_VECTOR`, 32'h0000_0100: PC loaded on a misaligned-redirect trap; must be word-aligned.
- `DRAIN_CYCLES`, 3: NOP cycles injected before `halted` asserts; range 1–15.
- `CNT_W`, 16: width of the performance counters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_redirect_valid` in 1: EX resolved a taken branch/jump this cycle.
- `ex_redirect_target` in 32: redirect target address.
- `id_load_use` in 1: ID instruction depends on the load currently in EX.
- `halt_req` in 1: level request to halt fetch.
- `resume_req` in 1: single-cycle pulse leaving HALTED.
- `if_stall` out 1: to fetch `stall`.
- `if_flush` out 1: to fetch `flush` (forces NOP 32'h00000013).
- `if_pc_sel` out 1: to fetch `pc_sel`.
- `if_pc_in` out 32: to fetch `pc_in`.
- `id_stall` out 1: hold the IF/ID register.
- `id_flush` out 1: zero the IF/ID register to a NOP.
- `ex_bubble` out 1: insert a NOP into ID/EX.
- `trap_valid` out 1: one-cycle pulse on trap.
- `trap_epc` out 32: registered faulting target, held until the next trap.
- `halted` out 1: pipeline drained and stopped.
- `stall_count` out CNT_W: load-use stall cycles, wraps.
- `flush_count` out CNT_W: redirects plus traps taken, wraps.

## Operation
- States: RUN, DRAIN, HALTED.
  - All control outputs are combinational from the state and current inputs.
  - The state, drain counter, `trap_epc` and counters are registered.
- Event priority within a cycle: trap/redirect > load-use > halt.
- Redirect is valid in RUN or DRAIN, with `ex_redirect_target[1:0]==0`:
  - Drive `if_pc_sel=1`, `if_pc_in=target`, `if_flush=1`, `id_flush=1`, `if_stall=0`.
  - `flush_count`++.
- Misaligned redirect (`target[1:0]!=0`):
  - Same as a redirect, but `if_pc_in=TRAP_VECTOR`.
  - `trap_valid=1`; `trap_epc<=target` at the edge.
  - `flush_count`++.
- Load-use, in RUN with no redirect:
  - `if_stall=1`, `id_stall=1`, `ex_bubble=1`.
  - `stall_count`++.
  - Lasts exactly the cycles `id_load_use` is high.
- RUN→DRAIN: `halt_req` is high and no redirect or trap occurs this cycle.
  - Load drain counter with DRAIN_CYCLES.
- DRAIN: each cycle drive `if_stall=1`, `if_flush=1`, `id_flush=1`; decrement the counter.
  - Counter reaches 1 → HALTED at the next edge.
  - Redirect/trap in DRAIN: take it (with `if_stall=0` that cycle) and reload the counter with DRAIN_CYCLES.
  - `id_load_use` is ignored in DRAIN.
- HALTED: `halted=1`, `if_stall=1`, `if_flush=1`, `id_flush=1`.
  - `resume_req` → RUN next cycle.
  - Redirects in HALTED are ignored (the pipeline is empty).
  - `halt_req` deasserting without `resume_req` keeps HALTED.
- `halt_req` dropped during DRAIN → back to RUN next cycle.
- Counters wrap modulo 2^CNT_W; no saturation.
- Idle defaults: all 1-bit outputs 0, `if_pc_in=0`.

## Timing
- Reset (synchronous) applies at the edge where `reset=1`:
  - State → RUN; drain counter, `trap_epc`, `stall_count`, `flush_count` → 0.
  - During reset all combinational outputs are forced to their idle value 0.
- Reset mid-DRAIN or in HALTED returns to RUN with no trap and no count.
- Redirect latency: requested in cycle T → fetch PC equals target (or TRAP_VECTOR) in T+1; the wrong-path instruction is killed in T.
- Load-use: one stall cycle per asserted cycle; PC unchanged across the edge.
- Halt: `halt_req` rises in T → `halted=1` in cycle T+DRAIN_CYCLES+1.
- `trap_valid` is a single-cycle pulse in the trap cycle; `trap_epc` is visible from T+1.

## Structure
- Shared package `fetch_ctrl_pkg` holds:
  - state enum `fc_state_e` (RUN, DRAIN, HALTED);
  - `NOP_INSTR` = 32'h00000013;
  - default `TRAP_VECTOR`.
- One sub-module, `event_counter` (CNT_W, inc, clk, reset), instantiated twice for `stall_count` and `flush_count`.

## Test plan
- Reset then idle 5 cycles → all outputs 0, counters 0, state RUN.
- Redirect to 32'h40 in cycle T → `if_pc_sel=1`, `if_pc_in=32'h40`, `if_flush=id_flush=1` in T; `flush_count=1`.
- Redirect to 32'h42 → `if_pc_in=32'h100`, `trap_valid` pulse, `trap_epc=32'h42`, `flush_count`++.
- `id_load_use` for 2 cycles concurrent with a redirect in cycle 2 → cycle 1 stalls, cycle 2 redirects with no stall; `stall_count=1`.
- `halt_req` at T with DRAIN_CYCLES=3 → `halted` at T+4; `resume_req` → RUN next cycle, `if_stall=0`.
- Redirect in the second DRAIN cycle → counter reloads; `halted` 4 cycles after the redirect. Preload `stall_count` to 16'hFFFF, one stall → wraps to 0.
